// File: rtl/sum_job_sched.sv
// sum_job_sched: round-robin scheduler sharing one summer core among
// NUM_REQ requesters, with auto/manual release and a valid/ready response.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/data     per-requester operand pending / operands (packed)
//   req_ready          one-hot accept strobe (combinational, IDLE only)
//   manual, user_btn   release mode select / debounced button level
//   core_ready         core idle
//   core_send_data     core send strobe
//   core_sum           core sum
//   core_start         core start pulse
//   core_btn           core release pulse
//   core_num_ddr       operand to core
//   rsp_valid/ready    response handshake
//   rsp_data/id/err    captured sum, served id, missing send strobe
//   busy               scheduler not idle
module sum_job_sched #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          manual,
    input  logic                          user_btn,
    input  logic                          core_ready,
    input  logic                          core_send_data,
    input  logic [DATA_WIDTH-1:0]         core_sum,
    output logic                          core_start,
    output logic                          core_btn,
    output logic [DATA_WIDTH-1:0]         core_num_ddr,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic                          rsp_err,
    output logic                          busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RELEASE,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       last_id_q, last_id_d;
    logic [ID_W-1:0]       job_id_q, job_id_d;
    logic [DATA_WIDTH-1:0] op_q, op_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  manual_q, manual_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  user_btn_q;

    logic [DATA_WIDTH-1:0] req_op [NUM_REQ];
    logic                  grant_vld;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W-1:0]       rr_idx_w;
    int                    rr_idx;
    logic                  accept;
    logic                  btn_edge;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_op[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First pending requester after last_id, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        rr_idx    = 0;
        rr_idx_w  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = int'(last_id_q) + k;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            rr_idx_w = ID_W'(rr_idx);
            if (!grant_vld && req_valid[rr_idx_w]) begin
                grant_vld = 1'b1;
                grant_id  = rr_idx_w;
            end
        end
    end

    assign accept    = (state_q == IDLE) && grant_vld && core_ready;
    assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;
    assign btn_edge  = user_btn & ~user_btn_q;

    always_comb begin
        state_d    = state_q;
        last_id_d  = last_id_q;
        job_id_d   = job_id_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        manual_d   = manual_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = req_op[grant_id];
                    job_id_d = grant_id;
                    // Mode is frozen for the whole job.
                    manual_d = manual;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (manual_q) begin
                    if (btn_edge) begin
                        state_d = RELEASE;
                    end
                end else if (cnt_q == '0) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RELEASE: begin
                rsp_data_d = core_sum;
                rsp_err_d  = ~core_send_data;
                rsp_id_d   = job_id_q;
                last_id_d  = job_id_q;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_id_q  <= ID_W'(NUM_REQ - 1);
            job_id_q   <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rsp_err_q  <= 1'b0;
            manual_q   <= 1'b0;
            cnt_q      <= '0;
            user_btn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_id_q  <= last_id_d;
            job_id_q   <= job_id_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
            manual_q   <= manual_d;
            cnt_q      <= cnt_d;
            user_btn_q <= user_btn;
        end
    end

    assign core_start   = (state_q == ISSUE);
    assign core_btn     = (state_q == RELEASE);
    assign core_num_ddr = op_q;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_data     = rsp_data_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = (state_q != IDLE);

endmodule
